ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_defs.sv | 21 ++
 rtl/ps2_sync.sv | 36 +++
 rtl/ps2_host_tx.sv | 180 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_defs.sv
// Shared PS/2 definitions: host transmit states, frame shape and a
// helper that turns microsecond timings into clock-cycle counts.
package ps2_defs;

  localparam int DATA_BITS  = 8;
  localparam int SEND_EDGES = 10;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SEND,
    ACK,
    WAIT_IDLE
  } state_t;

  function automatic longint us_to_cycles(input longint freq_hz, input longint us);
    return (freq_hz * us) / 64'd1_000_000;
  endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchronizers for the PS/2 clock and data lines plus a
// falling-edge detector on the synchronized clock.
module ps2_sync (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic clk_s,
  output logic data_s,
  output logic clk_fall
);

  logic clk_meta;
  logic data_meta;
  logic clk_prev;

  // Idle PS/2 lines float high, so every stage resets to 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_meta  <= 1'b1;
      clk_s     <= 1'b1;
      clk_prev  <= 1'b1;
      data_meta <= 1'b1;
      data_s    <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk;
      clk_s     <= clk_meta;
      clk_prev  <= clk_s;
      data_meta <= ps2_data;
      data_s    <= data_meta;
    end
  end

  assign clk_fall = clk_prev & ~clk_s;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, clock
// out ten bits on device falling edges, check the ack, then wait for idle.
module ps2_host_tx
  import ps2_defs::*;
#(
  parameter int CLK_FREQ   = 48000000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_US = 15000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       done,
  output logic       error
);

  localparam longint INHIBIT_CYCLES = us_to_cycles(CLK_FREQ, INHIBIT_US);
  localparam longint RTS_CYCLES     = us_to_cycles(CLK_FREQ, 1);
  localparam longint TIMEOUT_CYCLES = us_to_cycles(CLK_FREQ, TIMEOUT_US);
  localparam longint DLY_MAX = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int     DLY_W   = $clog2(DLY_MAX + 1);
  localparam int     TMO_W   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [DLY_W-1:0] INHIBIT_LAST = DLY_W'(INHIBIT_CYCLES - 1);
  localparam logic [DLY_W-1:0] RTS_LAST     = DLY_W'(RTS_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST     = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       PARITY_EDGE  = 4'(DATA_BITS);
  localparam logic [3:0]       STOP_EDGE    = 4'(SEND_EDGES - 1);

  state_t           state, state_nx;
  logic [7:0]       data_reg, data_nx;
  logic             parity, parity_nx;
  logic [3:0]       edge_cnt, edge_nx;
  logic [DLY_W-1:0] dly, dly_nx;
  logic [TMO_W-1:0] tmo, tmo_nx;
  logic             ack_flag, ack_nx;
  logic             clk_oe_nx, data_oe_nx, done_nx, error_nx;
  logic             clk_s, data_s, clk_fall;
  logic             timed;

  ps2_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .clk_s    (clk_s),
    .data_s   (data_s),
    .clk_fall (clk_fall)
  );

  assign ready = (state == IDLE);
  assign timed = (state == SEND) || (state == ACK) || (state == WAIT_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      data_reg    <= '0;
      parity      <= 1'b0;
      edge_cnt    <= '0;
      dly         <= '0;
      tmo         <= '0;
      ack_flag    <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      state       <= state_nx;
      data_reg    <= data_nx;
      parity      <= parity_nx;
      edge_cnt    <= edge_nx;
      dly         <= dly_nx;
      tmo         <= tmo_nx;
      ack_flag    <= ack_nx;
      ps2_clk_oe  <= clk_oe_nx;
      ps2_data_oe <= data_oe_nx;
      done        <= done_nx;
      error       <= error_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    data_nx    = data_reg;
    parity_nx  = parity;
    edge_nx    = edge_cnt;
    dly_nx     = dly;
    tmo_nx     = tmo;
    ack_nx     = ack_flag;
    clk_oe_nx  = ps2_clk_oe;
    data_oe_nx = ps2_data_oe;
    done_nx    = 1'b0;
    error_nx   = 1'b0;

    // The device must keep clocking; any falling edge restarts the timeout.
    if (timed) begin
      tmo_nx = clk_fall ? '0 : tmo + TMO_W'(1);
    end

    case (state)
      IDLE: begin
        if (valid && ready) begin
          data_nx    = data;
          parity_nx  = ~^data;
          edge_nx    = '0;
          dly_nx     = '0;
          tmo_nx     = '0;
          ack_nx     = 1'b0;
          clk_oe_nx  = 1'b1;
          data_oe_nx = 1'b0;
          state_nx   = INHIBIT;
        end
      end
      INHIBIT: begin
        if (dly == INHIBIT_LAST) begin
          dly_nx     = '0;
          data_oe_nx = 1'b1;
          state_nx   = RTS;
        end else begin
          dly_nx = dly + DLY_W'(1);
        end
      end
      RTS: begin
        if (dly == RTS_LAST) begin
          dly_nx    = '0;
          tmo_nx    = '0;
          clk_oe_nx = 1'b0;
          state_nx  = SEND;
        end else begin
          dly_nx = dly + DLY_W'(1);
        end
      end
      SEND: begin
        if (clk_fall) begin
          edge_nx = edge_cnt + 4'd1;
          if (edge_cnt < PARITY_EDGE) begin
            data_oe_nx = ~data_reg[edge_cnt[2:0]];
          end else if (edge_cnt == PARITY_EDGE) begin
            data_oe_nx = ~parity;
          end else if (edge_cnt == STOP_EDGE) begin
            data_oe_nx = 1'b0;
            state_nx   = ACK;
          end
        end
      end
      ACK: begin
        if (clk_fall) begin
          ack_nx   = ~data_s;
          error_nx = data_s;
          state_nx = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (clk_s && data_s) begin
          done_nx  = ack_flag;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    // A silent device aborts the frame and frees both lines.
    if (timed && !clk_fall && (tmo == TMO_LAST) &&
        !((state == WAIT_IDLE) && clk_s && data_s)) begin
      error_nx   = 1'b1;
      done_nx    = 1'b0;
      clk_oe_nx  = 1'b0;
      data_oe_nx = 1'b0;
      tmo_nx     = '0;
      state_nx   = IDLE;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx: a behavioural keyboard clocks frames
// in, and a monitor matches every done/error pulse against expected outcomes.
module tb_ps2_host_tx;

  localparam int CLK_FREQ   = 4_000_000;
  localparam int INHIBIT_US = 100;
  localparam int TIMEOUT_US = 2000;
  localparam int INH_CYC    = 400;
  localparam int RTS_CYC    = 4;
  localparam int TMO_CYC    = 8000;
  localparam int HALF       = 160;
  localparam int WAIT_MAX   = 20000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data = 8'h00;
  logic       valid = 1'b0;
  logic       ready, ps2_clk_oe, ps2_data_oe, done, error;
  logic       ps2_clk, ps2_data;
  logic       dev_clk = 1'b0;
  logic       dev_data = 1'b0;

  typedef struct {
    logic [7:0] b;
    logic       par;
    bit         frame;
    bit         done_exp;
  } exp_t;

  typedef struct {
    logic [7:0] b;
    logic       par;
    logic       stop;
  } rx_t;

  exp_t exp_q[$];
  rx_t  rx_q[$];
  exp_t e;
  rx_t  r;
  int   checks = 0;
  int   errors = 0;
  logic prev_pulse = 1'b0;

  assign ps2_clk  = !(ps2_clk_oe || dev_clk);
  assign ps2_data = !(ps2_data_oe || dev_data);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .CLK_FREQ   (CLK_FREQ),
    .INHIBIT_US (INHIBIT_US),
    .TIMEOUT_US (TIMEOUT_US)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .data        (data),
    .valid       (valid),
    .ready       (ready),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .done        (done),
    .error       (error)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: each done/error pulse consumes one expected outcome.
  always @(negedge clk) begin
    if (prev_pulse) check_output("pulse_one_cycle", 32'(done || error), 32'd0);
    prev_pulse = done || error;
    if (reset && (done || error)) begin
      check_output("done_error_exclusive", 32'(done && error), 32'd0);
      if (exp_q.size() == 0) begin
        check_output("unexpected_pulse", {30'd0, done, error}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_output("outcome_done", 32'(done), 32'(e.done_exp));
        check_output("outcome_error", 32'(error), 32'(!e.done_exp));
        if (e.frame) begin
          if (rx_q.size() == 0) begin
            check_output("frame_received", 32'd0, 32'd1);
          end else begin
            r = rx_q.pop_front();
            check_output("frame_byte", 32'(r.b), 32'(e.b));
            check_output("frame_parity", 32'(r.par), 32'(e.par));
            check_output("frame_stop", 32'(r.stop), 32'd1);
          end
        end
      end
    end
  end

  task automatic expect_result(input logic [7:0] b, input logic par, input bit frame, input bit done_exp);
    exp_t x;
    x.b = b; x.par = par; x.frame = frame; x.done_exp = done_exp;
    exp_q.push_back(x);
  endtask

  // Keyboard model: waits out inhibit/RTS, then clocks n_edges falling edges.
  task automatic device_run(input int n_edges, input bit ack, input bit measure);
    int n, inh, rts;
    logic [10:0] bits;
    rx_t x;
    n = 0;
    while (!ps2_clk_oe && n < WAIT_MAX) begin @(negedge clk); n++; end
    if (!ps2_clk_oe) begin
      check_output("wait_inhibit", 32'd0, 32'd1);
      return;
    end
    inh = 0;
    while (ps2_clk_oe && !ps2_data_oe && inh < WAIT_MAX) begin inh++; @(negedge clk); end
    rts = 0;
    while (ps2_clk_oe && ps2_data_oe && rts < WAIT_MAX) begin rts++; @(negedge clk); end
    if (measure) begin
      check_output("inhibit_cycles", 32'(inh), 32'(INH_CYC));
      check_output("rts_cycles", 32'(rts), 32'(RTS_CYC));
      check_output("start_bit_data_oe", 32'(ps2_data_oe), 32'd1);
      check_output("send_clk_released", 32'(ps2_clk_oe), 32'd0);
    end
    bits = '0;
    for (int i = 1; i <= 10 && i <= n_edges; i++) begin
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      bits[i] = ps2_data;
      dev_clk = 1'b0;
    end
    if (n_edges >= 10) begin
      x.b = bits[8:1]; x.par = bits[9]; x.stop = bits[10];
      rx_q.push_back(x);
    end
    if (n_edges >= 11) begin
      repeat (HALF/2) @(negedge clk);
      dev_data = ack;
      repeat (HALF/2) @(negedge clk);
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b0;
      repeat (HALF/2) @(negedge clk);
      dev_data = 1'b0;
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] b);
    int n;
    @(negedge clk);
    data = b;
    valid = 1'b1;
    n = 0;
    while (!ready && n < WAIT_MAX) begin @(negedge clk); n++; end
    if (!ready) check_output("ready_wait", 32'd0, 32'd1);
    @(negedge clk);
    valid = 1'b0;
    check_output("ready_low_busy", 32'(ready), 32'd0);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!ready && n < WAIT_MAX) begin @(negedge clk); n++; end
    check_output("ready_return", 32'(ready), 32'd1);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_output("reset_ready", 32'(ready), 32'd1);
    check_output("reset_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check_output("reset_data_oe", 32'(ps2_data_oe), 32'd0);
    check_output("reset_pulses", {30'd0, done, error}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check_output("post_reset_ready", 32'(ready), 32'd1);

    $display("[TB] 0xED with ack");
    expect_result(8'hED, 1'b1, 1'b1, 1'b1);
    fork
      device_run(11, 1'b1, 1'b1);
      apply_stimulus(8'hED);
    join
    wait_ready();

    $display("[TB] 0xF4 without ack");
    expect_result(8'hF4, 1'b0, 1'b1, 1'b0);
    fork
      device_run(11, 1'b0, 1'b0);
      apply_stimulus(8'hF4);
    join
    wait_ready();

    $display("[TB] 0x00 with silent device");
    expect_result(8'h00, 1'b1, 1'b0, 1'b0);
    apply_stimulus(8'h00);
    n = 0;
    while (ps2_clk_oe && n < WAIT_MAX) begin @(negedge clk); n++; end
    n = 0;
    while (!error && n < TMO_CYC + 50) begin @(negedge clk); n++; end
    check_output("timeout_cycles", 32'(n), 32'(TMO_CYC));
    check_output("timeout_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    check_output("timeout_ready", 32'(ready), 32'd1);

    $display("[TB] 0xAA held valid, then 0x55");
    expect_result(8'hAA, 1'b1, 1'b1, 1'b1);
    expect_result(8'h55, 1'b1, 1'b1, 1'b1);
    fork
      begin
        device_run(11, 1'b1, 1'b0);
        device_run(11, 1'b1, 1'b0);
      end
      begin
        @(negedge clk);
        data = 8'hAA;
        valid = 1'b1;
        n = 0;
        while (!ready && n < WAIT_MAX) begin @(negedge clk); n++; end
        @(negedge clk);
        data = 8'h55;
        check_output("hold_valid_ready_low", 32'(ready), 32'd0);
        n = 0;
        while (!ready && n < WAIT_MAX) begin @(negedge clk); n++; end
        @(negedge clk);
        valid = 1'b0;
        check_output("second_accepted", 32'(ready), 32'd0);
      end
    join
    wait_ready();

    $display("[TB] reset during bit 4 of 0x07");
    fork
      device_run(4, 1'b0, 1'b0);
      apply_stimulus(8'h07);
    join
    check_output("mid_frame_data_oe", 32'(ps2_data_oe), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_output("async_reset_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    check_output("async_reset_ready", 32'(ready), 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (50) @(negedge clk);

    $display("[TB] 0xFF after reset");
    expect_result(8'hFF, 1'b1, 1'b1, 1'b1);
    fork
      device_run(11, 1'b1, 1'b0);
      apply_stimulus(8'hFF);
    join
    wait_ready();

    repeat (20) @(negedge clk);
    check_output("outcomes_pending", 32'(exp_q.size()), 32'd0);
    check_output("frames_pending", 32'(rx_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
